// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: per-digit decode, blanking,
// blinking, decimal points, leading-zero suppression and tear-free updates.

// One digit lane: nibble decode plus the "dark" conditions. Outputs are
// active-high "lit" bits; polarity is applied once at the top level.
module seg7_digit #(
    parameter int HEX_EN = 1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    input  logic       blink,
    input  logic       blink_ph,
    input  logic       lz_zero,
    output logic [6:0] seg_lit,
    output logic       dp_lit
);
    logic [6:0] code_low;
    logic       dark;

    // Decode table written in active-low form {a,b,c,d,e,f,g}, then inverted.
    always_comb begin
        code_low = 7'b1111111;
        case (nibble)
            4'h0: code_low = 7'b0000001;
            4'h1: code_low = 7'b1001111;
            4'h2: code_low = 7'b0010010;
            4'h3: code_low = 7'b0000110;
            4'h4: code_low = 7'b1001100;
            4'h5: code_low = 7'b0100100;
            4'h6: code_low = 7'b0100000;
            4'h7: code_low = 7'b0001111;
            4'h8: code_low = 7'b0000000;
            4'h9: code_low = 7'b0000100;
            4'hA: code_low = (HEX_EN != 0) ? 7'b0001000 : 7'b1111111;
            4'hB: code_low = (HEX_EN != 0) ? 7'b1100000 : 7'b1111111;
            4'hC: code_low = (HEX_EN != 0) ? 7'b0110001 : 7'b1111111;
            4'hD: code_low = (HEX_EN != 0) ? 7'b1000010 : 7'b1111111;
            4'hE: code_low = (HEX_EN != 0) ? 7'b0110000 : 7'b1111111;
            default: code_low = (HEX_EN != 0) ? 7'b0111000 : 7'b1111111;
        endcase
    end

    // A dark digit loses segments and dp; its anode still scans normally.
    always_comb begin
        dark    = blank | (blink & blink_ph) | lz_zero;
        seg_lit = dark ? 7'b0000000 : ~code_low;
        dp_lit  = dp & ~dark;
    end
endmodule

module seg7_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_EN       = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  load,
    input  logic                  lz_suppress,
    output logic                  busy,
    output logic                  upd_done,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic          INV        = (ACTIVE_LOW != 0);

    logic [DW-1:0] div_cnt;
    logic [IW-1:0] digit_idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_ph;
    logic          frame_end;

    logic [N_DIGITS-1:0][3:0] act_value, pend_value;
    logic [N_DIGITS-1:0]      act_dp, act_blank, act_blink;
    logic [N_DIGITS-1:0]      pend_dp, pend_blank, pend_blink;

    logic [N_DIGITS-1:1]      zero_hi;
    logic [N_DIGITS-1:0][6:0] seg_lit;
    logic [N_DIGITS-1:0]      dp_lit;
    logic [N_DIGITS-1:0]      an_sel;
    logic [6:0]               seg_cur;
    logic                     dp_cur;

    assign frame_end = (digit_idx == IDX_LAST) && (div_cnt == DIV_LAST);
    assign an_sel    = N_DIGITS'(1) << digit_idx;
    assign seg_cur   = seg_lit[digit_idx];
    assign dp_cur    = dp_lit[digit_idx];

    // Slot divider, digit scan, and frame/blink timebase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    // Load capture into pending; pending moves to active only at a frame end
    // so a frame never shows a mix of old and new digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_blink  <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_blink <= '0;
            busy       <= 1'b0;
            upd_done   <= 1'b0;
        end else begin
            upd_done <= frame_end & busy;
            if (frame_end && busy) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
                act_blink <= pend_blink;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_mask;
                pend_blink <= blink_mask;
            end
            busy <= load | (busy & ~frame_end);
        end
    end

    // zero_hi[k]: nibbles k..N_DIGITS-1 are all zero (digit 0 never needs it).
    always_comb begin
        zero_hi = '0;
        zero_hi[N_DIGITS-1] = (act_value[N_DIGITS-1] == 4'd0);
        for (int k = N_DIGITS - 2; k >= 1; k--)
            zero_hi[k] = zero_hi[k+1] && (act_value[k] == 4'd0);
    end

    // One decode lane per digit; the scan picks a lane by digit_idx.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic lz_zero;
        if (k == 0) begin : g_lsd
            assign lz_zero = 1'b0;
        end else begin : g_upper
            assign lz_zero = lz_suppress & zero_hi[k];
        end
        seg7_digit #(.HEX_EN(HEX_EN)) u_digit (
            .nibble   (act_value[k]),
            .dp       (act_dp[k]),
            .blank    (act_blank[k]),
            .blink    (act_blink[k]),
            .blink_ph (blink_ph),
            .lz_zero  (lz_zero),
            .seg_lit  (seg_lit[k]),
            .dp_lit   (dp_lit[k])
        );
    end

    // Registered outputs; last cycle of each slot is all-off to avoid ghosting.
    always_ff @(posedge clk) begin
        if (!rst_n || div_cnt == DIV_LAST) begin
            an_out  <= {N_DIGITS{INV}};
            seg_out <= {7{INV}};
            dp_out  <= INV;
        end else begin
            an_out  <= an_sel ^ {N_DIGITS{INV}};
            seg_out <= seg_cur ^ {7{INV}};
            dp_out  <= dp_cur ^ INV;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: table of load vectors checked slot by slot
// through an expected-slot queue, plus reset, blink and load-race sequences.
module tb_seg7_scan_driver;
    localparam logic [6:0] C0 = 7'b0000001, C1 = 7'b1001111, C2 = 7'b0010010,
                           C3 = 7'b0000110, C5 = 7'b0100100,
                           C6 = 7'b0100000, C7 = 7'b0001111, C8 = 7'b0000000,
                           C9 = 7'b0000100, CA = 7'b0001000, CB = 7'b1100000,
                           CC = 7'b0110001, CD = 7'b1000010, CE = 7'b0110000,
                           CF = 7'b0111000, BL = 7'b1111111;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][6:0] seg_hex;   // {d3,d2,d1,d0}
        logic [3:0][6:0] seg_nohex;
        logic [3:0]      dp_exp;    // active-low dp per digit
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg_a;
        logic [6:0] seg_b;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in, blank_mask, blink_mask;
    logic        load, lz_suppress;
    logic        busy, upd_done, dp_out;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        busy_b, upd_b, dp_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2),
                       .HEX_EN(1), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .load(load),
        .lz_suppress(lz_suppress), .busy(busy), .upd_done(upd_done),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out));

    seg7_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2),
                       .HEX_EN(0), .ACTIVE_LOW(1)) dut_nohex (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .load(load),
        .lz_suppress(lz_suppress), .busy(busy_b), .upd_done(upd_b),
        .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b));

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push_slots(input logic [3:0][6:0] sa, input logic [3:0][6:0] sbx,
                              input logic [3:0] dpe);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.an    = ~(4'b0001 << d);
            e.seg_a = sa[d];
            e.seg_b = sbx[d];
            e.dp    = dpe[d];
            sb.push_back(e);
        end
    endtask

    // Consumes one full frame (4 slots x 4 cycles), starting at digit 0.
    task automatic check_frame(input string tag);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e = sb.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (d == 0 && c == 0) cmp({tag, " upd_done low"}, 16'(upd_done), 16'd0);
                if (c == 1) begin
                    cmp({tag, " an"},     16'(an_out),  16'(e.an));
                    cmp({tag, " seg"},    16'(seg_out), 16'(e.seg_a));
                    cmp({tag, " dp"},     16'(dp_out),  16'(e.dp));
                    cmp({tag, " an_nh"},  16'(an_b),    16'(e.an));
                    cmp({tag, " seg_nh"}, 16'(seg_b),   16'(e.seg_b));
                    cmp({tag, " dp_nh"},  16'(dp_b),    16'(e.dp));
                end
                if (c == 3) begin
                    cmp({tag, " guard an"},  16'(an_out),  16'hF);
                    cmp({tag, " guard seg"}, 16'(seg_out), 16'h7F);
                end
            end
        end
    endtask

    task automatic wait_upd(input string tag);
        int i;
        for (i = 0; i < 200 && upd_done !== 1'b1; i++) @(negedge clk);
        cmp({tag, " upd_done seen"}, 16'(upd_done), 16'd1);
        cmp({tag, " upd_done nh"},   16'(upd_b),    16'd1);
        cmp({tag, " busy cleared"},  16'(busy),     16'd0);
    endtask

    task automatic count_upd(input string tag, input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (upd_done === 1'b1) n++;
        end
        cmp({tag, " extra upd_done"}, 16'(n), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {C1, C2, CA, CF}, {C1, C2, BL, BL}, 4'b1111};
        vecs[1] = '{16'h0005, 4'b1111, 4'b0000, 1'b1, {BL, BL, BL, C5}, {BL, BL, BL, C5}, 4'b1110};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {BL, BL, BL, C0}, {BL, BL, BL, C0}, 4'b1111};
        vecs[3] = '{16'h3456, 4'b1010, 4'b0100, 1'b0, {C3, BL, C5, C6}, {C3, BL, C5, C6}, 4'b0101};
        vecs[4] = '{16'h7809, 4'b0001, 4'b0000, 1'b1, {C7, C8, C0, C9}, {C7, C8, C0, C9}, 4'b1110};
        vecs[5] = '{16'h0BCD, 4'b0000, 4'b0000, 1'b1, {BL, CB, CC, CD}, {BL, BL, BL, BL}, 4'b1111};
        vecs[6] = '{16'h00E0, 4'b0000, 4'b0000, 1'b1, {BL, BL, CE, C0}, {BL, BL, BL, C0}, 4'b1111};

        rst_n = 1'b0; value = '0; dp_in = '0; blank_mask = '0; blink_mask = '0;
        load = 1'b0; lz_suppress = 1'b0;

        // Reset state, then the first frame after release shows all zeros.
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst seg",  16'(seg_out),  16'h7F);
        cmp("rst an",   16'(an_out),   16'hF);
        cmp("rst dp",   16'(dp_out),   16'd1);
        cmp("rst busy", 16'(busy),     16'd0);
        cmp("rst upd",  16'(upd_done), 16'd0);
        rst_n = 1'b1;
        push_slots({C0, C0, C0, C0}, {C0, C0, C0, C0}, 4'b1111);
        check_frame("post-reset");

        // Table vectors: load, tear-free apply, one full frame checked.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            value = vecs[v].value; dp_in = vecs[v].dp; blank_mask = vecs[v].blank;
            blink_mask = '0; lz_suppress = vecs[v].lz; load = 1'b1;
            push_slots(vecs[v].seg_hex, vecs[v].seg_nohex, vecs[v].dp_exp);
            @(negedge clk);
            load = 1'b0;
            cmp($sformatf("vec%0d busy", v), 16'(busy), 16'd1);
            wait_upd($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v));
        end

        // Blink: digit 0 blinks with 2-frame half period, dp follows lit state.
        @(negedge clk);
        rst_n = 1'b0; value = '0; dp_in = '0; blank_mask = '0; lz_suppress = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; blink_mask = 4'b0001; dp_in = 4'b0001; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_upd("blink");
        begin
            bit lit_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int f = 0; f < 6; f++) begin
                if (lit_pat[f]) push_slots({C0, C0, C0, C0}, {C0, C0, C0, C0}, 4'b1110);
                else            push_slots({C0, C0, C0, BL}, {C0, C0, C0, BL}, 4'b1111);
                check_frame($sformatf("blink f%0d", f + 1));
            end
        end

        // Two loads before one boundary: last wins, single upd_done.
        @(negedge clk);
        rst_n = 1'b0; blink_mask = '0; dp_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; value = 16'h1111; load = 1'b1;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        wait_upd("lastwins");
        push_slots({C2, C2, C2, C2}, {C2, C2, C2, C2}, 4'b1111);
        check_frame("lastwins");
        count_upd("lastwins", 32);

        // Reset while busy discards the pending load.
        @(negedge clk);
        value = 16'h5555; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cmp("abort busy set", 16'(busy), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        cmp("abort busy clr", 16'(busy), 16'd0);
        rst_n = 1'b1;
        push_slots({C0, C0, C0, C0}, {C0, C0, C0, C0}, 4'b1111);
        check_frame("abort");
        count_upd("abort", 48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
